// File: rtl/vec_stream_pkg.sv
// Shared types and helpers for the vector streaming blocks.
package vec_stream_pkg;

  typedef enum logic [0:0] {
    VS_IDLE = 1'b0,
    VS_SEND = 1'b1
  } vs_state_e;

  // A beat counter for a single-beat vector still needs one bit.
  function automatic int vs_beat_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/vec_serialise_int_if.sv
// Vector-in / lane-beat-out bus of vec_serialise_int; o_psum exists only with VEC_SER_PSUM_EN.
interface vec_serialise_int_if
  import vec_stream_pkg::*;
#(
  parameter int bit_width = 16,
  parameter int length    = 32,
  parameter int lanes     = 4
) ();

  localparam int beats     = length / lanes;
  localparam int cnt_width = vs_beat_width(beats);
  localparam int sum_width = bit_width + $clog2(length);

  logic                        i_vec_valid;
  logic                        o_vec_ready;
  logic signed [bit_width-1:0] i_vec [length];
  logic                        o_lane_valid;
  logic                        i_lane_ready;
  logic signed [bit_width-1:0] o_lanes [lanes];
  logic [cnt_width-1:0]        o_beat;
  logic                        o_first;
  logic                        o_last;
`ifdef VEC_SER_PSUM_EN
  logic signed [sum_width-1:0] o_psum;
`endif

  modport slave (
    input  i_vec_valid, i_vec, i_lane_ready,
`ifdef VEC_SER_PSUM_EN
    output o_psum,
`endif
    output o_vec_ready, o_lane_valid, o_lanes, o_beat, o_first, o_last
  );

  modport master (
    output i_vec_valid, i_vec, i_lane_ready,
`ifdef VEC_SER_PSUM_EN
    input  o_psum,
`endif
    input  o_vec_ready, o_lane_valid, o_lanes, o_beat, o_first, o_last
  );

endinterface

// File: rtl/vec_sum_int.sv
// Combinational signed adder tree: full-precision sum of `length` elements.
module vec_sum_int #(
  parameter int length    = 4,
  parameter int bit_width = 16
) (
  input  logic signed [bit_width-1:0]                 i_vec [length],
  output logic signed [bit_width+$clog2(length)-1:0]  o_sum
);

  localparam int levels = $clog2(length);
  localparam int sw     = bit_width + levels;

  // Every level is computed at the final width so no stage can overflow.
  genvar gl, gi;
  generate
    for (gl = 0; gl <= levels; gl++) begin : lvl
      logic signed [sw-1:0] s [length >> gl];
      for (gi = 0; gi < (length >> gl); gi++) begin : node
        if (gl == 0) begin : leaf
          assign s[gi] = sw'(i_vec[gi]);
        end else begin : add
          assign s[gi] = lvl[gl-1].s[2*gi] + lvl[gl-1].s[2*gi+1];
        end
      end
    end
  endgenerate

  assign o_sum = lvl[levels].s[0];

endmodule

// File: rtl/vec_serialise_int.sv
// Serialises one parallel signed vector into length/lanes framed beats.
// Define VEC_SER_PSUM_EN to add the running partial-sum output o_psum.
module vec_serialise_int
  import vec_stream_pkg::*;
#(
  parameter int bit_width = 16,
  parameter int length    = 32,
  parameter int lanes     = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  vec_serialise_int_if.slave bus
);

  localparam int beats     = length / lanes;
  localparam int cnt_width = vs_beat_width(beats);
  localparam int sum_width = bit_width + $clog2(length);
  localparam logic [cnt_width-1:0] last_beat = cnt_width'(beats - 1);

  vs_state_e                   state_q, state_d;
  logic [cnt_width-1:0]        cnt_q, cnt_d;
  logic signed [bit_width-1:0] vec_q [length];
  logic signed [bit_width-1:0] vec_d [length];

  logic is_last;
  logic lane_valid;
  logic vec_ready;
  logic lane_fire;
  logic vec_accept;

  logic signed [bit_width-1:0] beat_view [beats][lanes];
  logic signed [bit_width-1:0] lane_data [lanes];

  assign is_last = (cnt_q == last_beat);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    vec_d      = vec_q;
    vec_ready  = 1'b0;
    lane_valid = 1'b0;
    case (state_q)
      VS_IDLE: vec_ready = 1'b1;
      VS_SEND: begin
        lane_valid = 1'b1;
        vec_ready  = is_last & bus.i_lane_ready;
      end
      default: state_d = VS_IDLE;
    endcase
    if (i_rst) vec_ready = 1'b0;
    lane_fire  = lane_valid & bus.i_lane_ready;
    vec_accept = vec_ready & bus.i_vec_valid;
    // A fresh vector on the last beat restarts framing with no idle cycle.
    if (vec_accept) begin
      vec_d   = bus.i_vec;
      cnt_d   = '0;
      state_d = VS_SEND;
    end else if (lane_fire) begin
      if (is_last) state_d = VS_IDLE;
      else         cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= VS_IDLE;
      cnt_q   <= '0;
      for (int i = 0; i < length; i++) vec_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
    end
  end

  genvar bi, gi;
  generate
    for (bi = 0; bi < beats; bi++) begin : g_beat
      for (gi = 0; gi < lanes; gi++) begin : g_elem
        assign beat_view[bi][gi] = vec_q[bi*lanes + gi];
      end
    end
    for (gi = 0; gi < lanes; gi++) begin : g_lane
      assign lane_data[gi]   = beat_view[cnt_q][gi];
      assign bus.o_lanes[gi] = lane_data[gi];
    end
  endgenerate

  assign bus.o_vec_ready  = vec_ready;
  assign bus.o_lane_valid = lane_valid;
  assign bus.o_beat       = cnt_q;
  assign bus.o_first      = lane_valid & (cnt_q == '0);
  assign bus.o_last       = lane_valid & is_last;

`ifdef VEC_SER_PSUM_EN
  localparam int lane_sum_width = bit_width + $clog2(lanes);

  logic signed [lane_sum_width-1:0] beat_sum;
  logic signed [sum_width-1:0]      beat_sum_ext;
  logic signed [sum_width-1:0]      acc_q, acc_d;

  vec_sum_int #(
    .length    (lanes),
    .bit_width (bit_width)
  ) u_beat_sum (
    .i_vec (lane_data),
    .o_sum (beat_sum)
  );

  assign beat_sum_ext = sum_width'(beat_sum);

  // acc holds the sum of beats already handed over; the current beat is added on the output.
  always_comb begin
    acc_d = acc_q;
    if (vec_accept)                acc_d = '0;
    else if (lane_fire & !is_last) acc_d = acc_q + beat_sum_ext;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign bus.o_psum = acc_q + beat_sum_ext;
`endif

endmodule

// File: tb/tb_vec_serialise_int.sv
// Scoreboard bench for vec_serialise_int (default 4-lane and single-beat 32-lane builds).
module tb_vec_serialise_int;

  localparam int BW  = 16;
  localparam int LEN = 32;
  localparam int LN  = 4;
  localparam int NB  = LEN / LN;
  localparam int LN1 = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vec_serialise_int_if #(.bit_width(BW), .length(LEN), .lanes(LN))  bus ();
  vec_serialise_int_if #(.bit_width(BW), .length(LEN), .lanes(LN1)) bus1 ();

  vec_serialise_int #(.bit_width(BW), .length(LEN), .lanes(LN)) u_dut (
    .i_clk (clk), .i_rst (rst), .bus (bus)
  );
  vec_serialise_int #(.bit_width(BW), .length(LEN), .lanes(LN1)) u_dut1 (
    .i_clk (clk), .i_rst (rst), .bus (bus1)
  );

  typedef struct packed {
    logic [LN*BW-1:0] lanes;
    int               beat;
    logic             first;
    logic             last;
    longint           psum;
  } beat_t;

  beat_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;
  logic signed [BW-1:0] vec_m [LEN];

  function automatic logic [LN*BW-1:0] pack_lanes();
    logic [LN*BW-1:0] p;
    for (int k = 0; k < LN; k++) p[k*BW +: BW] = bus.o_lanes[k];
    return p;
  endfunction

  task automatic fill(input int kind);
    for (int i = 0; i < LEN; i++) begin
      case (kind)
        0:       vec_m[i] = BW'(i);
        1:       vec_m[i] = BW'(i*7 - 100);
        2:       vec_m[i] = 16'sh8000;
        default: vec_m[i] = BW'($urandom);
      endcase
    end
  endtask

  task automatic drive_vec();
    for (int i = 0; i < LEN; i++) begin
      bus.i_vec[i]  = vec_m[i];
      bus1.i_vec[i] = vec_m[i];
    end
  endtask

  // Expected beats of the vector currently in vec_m.
  task automatic push_vector();
    beat_t  e;
    longint acc = 0;
    for (int b = 0; b < NB; b++) begin
      for (int k = 0; k < LN; k++) begin
        e.lanes[k*BW +: BW] = vec_m[b*LN + k];
        acc += longint'(vec_m[b*LN + k]);
      end
      e.beat  = b;
      e.first = (b == 0);
      e.last  = (b == NB - 1);
      e.psum  = acc;
      sb.push_back(e);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_vec_valid = 1'b0;  bus.i_lane_ready = 1'b0;
    bus1.i_vec_valid = 1'b0; bus1.i_lane_ready = 1'b0;
    fill(0); drive_vec();
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (bus.o_vec_ready !== 1'b0 || bus1.o_vec_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: o_vec_ready=%b/%b required 0 while i_rst=1", bus.o_vec_ready, bus1.o_vec_ready);
    end
    @(negedge clk); rst = 1'b0; #1;
    n_tests++;
    if (bus.o_vec_ready !== 1'b1 || bus.o_lane_valid !== 1'b0 || bus.o_beat !== 3'd0 ||
        pack_lanes() !== '0 || bus.o_first !== 1'b0 || bus.o_last !== 1'b0) begin
      n_fail++; $display("FAIL reset_state: ready=%b valid=%b beat=%0d lanes=%h first=%b last=%b required 1 0 0 0 0 0",
        bus.o_vec_ready, bus.o_lane_valid, bus.o_beat, pack_lanes(), bus.o_first, bus.o_last);
    end
`ifdef VEC_SER_PSUM_EN
    n_tests++;
    if (longint'(bus.o_psum) !== 64'sd0) begin
      n_fail++; $display("FAIL reset_psum: got %0d required 0", bus.o_psum);
    end
`endif
    $display("[TB] reset checked");
  endtask

  task automatic test_stream();
    int beats_seen = 0;
    int bubbles = 0;
    beat_t e;
    logic [LN*BW-1:0] got;
    logic [LN*BW-1:0] beat3_ref = 64'h000f_000e_000d_000c;
    fill(0);
    @(negedge clk); drive_vec(); bus.i_vec_valid = 1'b1; bus.i_lane_ready = 1'b1; #1;
    n_tests++;
    if (bus.o_vec_ready !== 1'b1) begin
      n_fail++; $display("FAIL stream_accept: o_vec_ready=%b required 1", bus.o_vec_ready);
    end
    push_vector();
    for (int cyc = 0; cyc < 20 && beats_seen < NB; cyc++) begin
      @(negedge clk); bus.i_vec_valid = 1'b0; #1;
      if (bus.o_lane_valid !== 1'b1) begin bubbles++; continue; end
      if (sb.size() == 0) begin n_fail++; $display("FAIL stream_extra: beat %0d with empty scoreboard", bus.o_beat); break; end
      e = sb.pop_front(); got = pack_lanes();
      n_tests++;
      if (got !== e.lanes || int'(bus.o_beat) !== e.beat || bus.o_first !== e.first || bus.o_last !== e.last) begin
        n_fail++; $display("FAIL stream_beat: lanes=%h beat=%0d first=%b last=%b required %h %0d %b %b",
          got, bus.o_beat, bus.o_first, bus.o_last, e.lanes, e.beat, e.first, e.last);
      end
`ifdef VEC_SER_PSUM_EN
      n_tests++;
      if (longint'(bus.o_psum) !== e.psum) begin
        n_fail++; $display("FAIL stream_psum: got %0d required %0d", bus.o_psum, e.psum);
      end
`endif
      if (e.beat == 3) begin
        n_tests++;
        if (got !== beat3_ref) begin
          n_fail++; $display("FAIL stream_beat3: lanes=%h required %h", got, beat3_ref);
        end
      end
      $display("[TB] stream beat %0d lanes=%h", e.beat, got);
      beats_seen++;
    end
    n_tests++;
    if (beats_seen != NB || bubbles != 0) begin
      n_fail++; $display("FAIL stream_count: beats=%0d bubbles=%0d required %0d 0", beats_seen, bubbles, NB);
    end
  endtask

  task automatic test_back_to_back();
    int accepted = 0;
    int beats_seen = 0;
    int bubbles = 0;
    beat_t e;
    for (int cyc = 0; cyc < 40 && beats_seen < 2*NB; cyc++) begin
      @(negedge clk);
      fill(accepted == 0 ? 0 : 1); drive_vec();
      bus.i_vec_valid = (accepted < 2); bus.i_lane_ready = 1'b1; #1;
      if (bus.o_lane_valid === 1'b1) begin
        if (sb.size() == 0) begin n_fail++; $display("FAIL b2b_extra: beat with empty scoreboard"); break; end
        e = sb.pop_front();
        n_tests++;
        if (pack_lanes() !== e.lanes || int'(bus.o_beat) !== e.beat || bus.o_first !== e.first ||
            bus.o_last !== e.last || bus.o_vec_ready !== e.last) begin
          n_fail++; $display("FAIL b2b_beat: lanes=%h beat=%0d first=%b last=%b ready=%b required %h %0d %b %b %b",
            pack_lanes(), bus.o_beat, bus.o_first, bus.o_last, bus.o_vec_ready, e.lanes, e.beat, e.first, e.last, e.last);
        end
`ifdef VEC_SER_PSUM_EN
        n_tests++;
        if (longint'(bus.o_psum) !== e.psum) begin
          n_fail++; $display("FAIL b2b_psum: got %0d required %0d", bus.o_psum, e.psum);
        end
`endif
        $display("[TB] b2b beat %0d ready=%b", e.beat, bus.o_vec_ready);
        beats_seen++;
      end else if (accepted > 0) begin
        bubbles++;
      end
      if (bus.i_vec_valid && bus.o_vec_ready === 1'b1) begin push_vector(); accepted++; end
    end
    bus.i_vec_valid = 1'b0;
    n_tests++;
    if (beats_seen != 2*NB || bubbles != 0 || accepted != 2) begin
      n_fail++; $display("FAIL b2b_count: beats=%0d bubbles=%0d accepted=%0d required %0d 0 2", beats_seen, bubbles, accepted, 2*NB);
    end
  endtask

  task automatic test_backpressure();
    int done = 0;
    int stalls = 0;
    beat_t e;
    fill(3);
    @(negedge clk); drive_vec(); bus.i_vec_valid = 1'b1; bus.i_lane_ready = 1'b1; #1;
    n_tests++;
    if (bus.o_vec_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_accept: o_vec_ready=%b required 1", bus.o_vec_ready);
    end
    push_vector();
    for (int cyc = 0; cyc < 30 && done < NB; cyc++) begin
      @(negedge clk); bus.i_vec_valid = 1'b0;
      bus.i_lane_ready = !(done == 2 && stalls < 3);
      if (!bus.i_lane_ready) stalls++;
      #1;
      if (bus.o_lane_valid !== 1'b1) continue;
      if (sb.size() == 0) begin n_fail++; $display("FAIL bp_extra: beat with empty scoreboard"); break; end
      e = sb[0];
      n_tests++;
      if (pack_lanes() !== e.lanes || int'(bus.o_beat) !== e.beat || bus.o_first !== e.first || bus.o_last !== e.last) begin
        n_fail++; $display("FAIL %s: lanes=%h beat=%0d first=%b last=%b required %h %0d %b %b",
          bus.i_lane_ready ? "bp_beat" : "bp_hold", pack_lanes(), bus.o_beat, bus.o_first, bus.o_last,
          e.lanes, e.beat, e.first, e.last);
      end
`ifdef VEC_SER_PSUM_EN
      n_tests++;
      if (longint'(bus.o_psum) !== e.psum) begin
        n_fail++; $display("FAIL bp_psum: got %0d required %0d", bus.o_psum, e.psum);
      end
`endif
      $display("[TB] bp beat %0d ready=%b", e.beat, bus.i_lane_ready);
      if (bus.i_lane_ready) begin void'(sb.pop_front()); done++; end
    end
    bus.i_lane_ready = 1'b1;
    n_tests++;
    if (done != NB || stalls != 3) begin
      n_fail++; $display("FAIL bp_count: beats=%0d stalls=%0d required %0d 3", done, stalls, NB);
    end
  endtask

  task automatic test_reset_mid();
    int done = 0;
    beat_t e;
    fill(0);
    @(negedge clk); drive_vec(); bus.i_vec_valid = 1'b1; bus.i_lane_ready = 1'b1; #1;
    push_vector();
    for (int cyc = 0; cyc < 20 && done < 4; cyc++) begin
      @(negedge clk); bus.i_vec_valid = 1'b0; #1;
      if (bus.o_lane_valid === 1'b1) begin void'(sb.pop_front()); done++; end
    end
    @(negedge clk); rst = 1'b1; #1;
    n_tests++;
    if (bus.o_vec_ready !== 1'b0 || int'(bus.o_beat) !== 4) begin
      n_fail++; $display("FAIL rstmid_pulse: ready=%b beat=%0d required 0 4", bus.o_vec_ready, bus.o_beat);
    end
    @(negedge clk); rst = 1'b0; sb.delete();
    fill(1); drive_vec(); bus.i_vec_valid = 1'b1; #1;
    n_tests++;
    if (bus.o_lane_valid !== 1'b0 || bus.o_beat !== 3'd0 || bus.o_vec_ready !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_idle: valid=%b beat=%0d ready=%b required 0 0 1", bus.o_lane_valid, bus.o_beat, bus.o_vec_ready);
    end
    push_vector();
    done = 0;
    for (int cyc = 0; cyc < 20 && done < NB; cyc++) begin
      @(negedge clk); bus.i_vec_valid = 1'b0; #1;
      if (bus.o_lane_valid !== 1'b1) continue;
      if (sb.size() == 0) begin n_fail++; $display("FAIL rstmid_extra: beat with empty scoreboard"); break; end
      e = sb.pop_front();
      n_tests++;
      if (pack_lanes() !== e.lanes || int'(bus.o_beat) !== e.beat || bus.o_first !== e.first || bus.o_last !== e.last) begin
        n_fail++; $display("FAIL rstmid_beat: lanes=%h beat=%0d first=%b last=%b required %h %0d %b %b",
          pack_lanes(), bus.o_beat, bus.o_first, bus.o_last, e.lanes, e.beat, e.first, e.last);
      end
      $display("[TB] rstmid beat %0d", e.beat);
      done++;
    end
    n_tests++;
    if (done != NB) begin
      n_fail++; $display("FAIL rstmid_count: beats=%0d required %0d", done, NB);
    end
  endtask

  task automatic test_single_beat();
    logic signed [BW-1:0] vec_a [LEN];
    int bad;
    fill(1); vec_a = vec_m;
    @(negedge clk); drive_vec(); bus1.i_vec_valid = 1'b1; bus1.i_lane_ready = 1'b1; #1;
    n_tests++;
    if (bus1.o_vec_ready !== 1'b1 || bus1.o_lane_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_accept: ready=%b valid=%b required 1 0", bus1.o_vec_ready, bus1.o_lane_valid);
    end
    @(negedge clk); fill(3); drive_vec(); #1;
    bad = 0;
    for (int k = 0; k < LN1; k++) if (bus1.o_lanes[k] !== vec_a[k]) bad++;
    n_tests++;
    if (bad != 0 || bus1.o_lane_valid !== 1'b1 || bus1.o_first !== 1'b1 || bus1.o_last !== 1'b1 ||
        bus1.o_beat !== 1'b0 || bus1.o_vec_ready !== 1'b1) begin
      n_fail++; $display("FAIL single_beat_a: bad_lanes=%0d valid=%b first=%b last=%b beat=%0d ready=%b required 0 1 1 1 0 1",
        bad, bus1.o_lane_valid, bus1.o_first, bus1.o_last, bus1.o_beat, bus1.o_vec_ready);
    end
    $display("[TB] single beat A bad_lanes=%0d", bad);
    @(negedge clk); bus1.i_vec_valid = 1'b0; #1;
    bad = 0;
    for (int k = 0; k < LN1; k++) if (bus1.o_lanes[k] !== vec_m[k]) bad++;
    n_tests++;
    if (bad != 0 || bus1.o_lane_valid !== 1'b1 || bus1.o_first !== 1'b1 || bus1.o_last !== 1'b1) begin
      n_fail++; $display("FAIL single_beat_b: bad_lanes=%0d valid=%b first=%b last=%b required 0 1 1 1",
        bad, bus1.o_lane_valid, bus1.o_first, bus1.o_last);
    end
    $display("[TB] single beat B bad_lanes=%0d", bad);
    @(negedge clk); #1;
    n_tests++;
    if (bus1.o_lane_valid !== 1'b0 || bus1.o_vec_ready !== 1'b1) begin
      n_fail++; $display("FAIL single_idle: valid=%b ready=%b required 0 1", bus1.o_lane_valid, bus1.o_vec_ready);
    end
  endtask

`ifdef VEC_SER_PSUM_EN
  task automatic test_psum();
    int done = 0;
    beat_t e;
    longint req;
    fill(2);
    @(negedge clk); drive_vec(); bus.i_vec_valid = 1'b1; bus.i_lane_ready = 1'b1; #1;
    push_vector();
    for (int cyc = 0; cyc < 20 && done < NB; cyc++) begin
      @(negedge clk); bus.i_vec_valid = 1'b0; #1;
      if (bus.o_lane_valid !== 1'b1) continue;
      if (sb.size() == 0) begin n_fail++; $display("FAIL psum_extra: beat with empty scoreboard"); break; end
      e = sb.pop_front();
      req = (done == 0) ? -64'sd131072 : (done == NB-1) ? -64'sd1048576 : -131072 * longint'(done + 1);
      n_tests++;
      if (longint'(bus.o_psum) !== req || pack_lanes() !== e.lanes) begin
        n_fail++; $display("FAIL psum_beat%0d: psum=%0d lanes=%h required %0d %h", done, bus.o_psum, pack_lanes(), req, e.lanes);
      end
      $display("[TB] psum beat %0d psum=%0d", done, bus.o_psum);
      done++;
    end
    n_tests++;
    if (done != NB) begin
      n_fail++; $display("FAIL psum_count: beats=%0d required %0d", done, NB);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_single_beat();
`ifdef VEC_SER_PSUM_EN
    test_psum();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
